// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for the single-port data RAM: fetch vs load/store unit,
// round-robin on ties, IDLE->ISSUE->RESP per access. Optional: RAM_ARB_MISALIGN_CHECK_EN.
module ram_arbiter #(
  parameter int         MXLEN = 32,
  parameter logic [2:0] F3_LW = 3'd2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             if_req,
  input  logic [MXLEN-1:0] if_addr,
  output logic             if_ack,
  output logic [MXLEN-1:0] if_rdata,
  input  logic             d_req,
  input  logic [MXLEN-1:0] d_addr,
  input  logic [MXLEN-1:0] d_wdata,
  input  logic             d_load,
  input  logic             d_store,
  input  logic [2:0]       d_ops,
  input  logic             d_kill,
  output logic             d_ack,
  output logic [MXLEN-1:0] d_rdata,
  output logic             d_err,
  output logic [MXLEN-1:0] ram_addr,
  output logic [MXLEN-1:0] ram_w_data,
  output logic             ram_load,
  output logic             ram_store,
  output logic [2:0]       ram_load_ops,
  output logic [2:0]       ram_store_ops,
  output logic             ram_exception,
  input  logic [MXLEN-1:0] ram_r_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t           state, state_nx;
  logic             sel_d;     // 1 = data port owns the access
  logic             last_d;    // round-robin history, 1 = data won last
  logic [MXLEN-1:0] addr_q, wdata_q;
  logic             load_q, store_q, mis_q;
  logic [2:0]       ops_q;
  logic             any_req, grant_d, mis_nx;

  assign any_req = if_req | d_req;
  assign grant_d = d_req & (~if_req | ~last_d);

`ifdef RAM_ARB_MISALIGN_CHECK_EN
  always_comb begin
    mis_nx = 1'b0;
    if (!grant_d)                mis_nx = |if_addr[1:0];
    else if (d_ops[1:0] == 2'b01) mis_nx = d_addr[0];
    else if (d_ops[1:0] == 2'b10) mis_nx = |d_addr[1:0];
  end
`else
  assign mis_nx = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    ram_addr      = '0;
    ram_w_data    = '0;
    ram_load      = 1'b0;
    ram_store     = 1'b0;
    ram_load_ops  = 3'd0;
    ram_store_ops = 3'd0;
    ram_exception = 1'b0;
    case (state)
      S_IDLE:  if (any_req) state_nx = S_ISSUE;
      S_ISSUE: begin
        state_nx      = S_RESP;
        ram_addr      = addr_q;
        ram_w_data    = wdata_q;
        // misaligned accesses still take the slot but never touch the RAM
        ram_load      = load_q & ~mis_q;
        ram_store     = store_q & ~mis_q;
        ram_load_ops  = load_q ? ops_q : 3'd0;
        ram_store_ops = store_q ? ops_q : 3'd0;
        ram_exception = sel_d & d_kill;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sel_d   <= 1'b0;
      last_d  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      ops_q   <= 3'd0;
      mis_q   <= 1'b0;
    end else if (state == S_IDLE && any_req) begin
      sel_d  <= grant_d;
      last_d <= grant_d;
      mis_q  <= mis_nx;
      if (grant_d) begin
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        load_q  <= d_load;
        store_q <= d_store;
        ops_q   <= d_ops;
      end else begin
        addr_q  <= if_addr;
        wdata_q <= '0;
        load_q  <= 1'b1;
        store_q <= 1'b0;
        ops_q   <= F3_LW;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (state == S_ISSUE) begin
      if (sel_d) d_rdata  <= (store_q || d_kill || mis_q) ? '0 : ram_r_data;
      else       if_rdata <= mis_q ? '0 : ram_r_data;
    end
  end

  assign if_ack = (state == S_RESP) & ~sel_d;
  assign d_ack  = (state == S_RESP) & sel_d;
  assign d_err  = (state == S_RESP) & sel_d & mis_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: byte RAM environment, transaction-level reference model with
// per-cycle output compare, directed scenarios then randomized two-port traffic.
module tb_ram_arbiter;
`ifdef RAM_ARB_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        CLK, RST_N;
  logic        if_req, if_ack, d_req, d_ack, d_err, d_load, d_store, d_kill;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [2:0]  d_ops, ram_load_ops, ram_store_ops;
  logic [31:0] ram_addr, ram_w_data, ram_r_data, ram_word;
  logic        ram_load, ram_store, ram_exception;
  logic        init_mem;

  ram_arbiter #(.MXLEN(32), .F3_LW(3'd2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_load(d_load), .d_store(d_store),
    .d_ops(d_ops), .d_kill(d_kill), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .ram_addr(ram_addr), .ram_w_data(ram_w_data), .ram_load(ram_load), .ram_store(ram_store),
    .ram_load_ops(ram_load_ops), .ram_store_ops(ram_store_ops),
    .ram_exception(ram_exception), .ram_r_data(ram_r_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- RAM environment (little-endian, 256 bytes) ----------------
  logic [7:0] ram_mem [256];
  always_comb begin
    ram_word = {ram_mem[ram_addr[7:0] + 8'd3], ram_mem[ram_addr[7:0] + 8'd2],
                ram_mem[ram_addr[7:0] + 8'd1], ram_mem[ram_addr[7:0]]};
    case (ram_load_ops)
      3'd0:    ram_r_data = {{24{ram_word[7]}}, ram_word[7:0]};
      3'd1:    ram_r_data = {{16{ram_word[15]}}, ram_word[15:0]};
      3'd4:    ram_r_data = {24'd0, ram_word[7:0]};
      3'd5:    ram_r_data = {16'd0, ram_word[15:0]};
      default: ram_r_data = ram_word;
    endcase
    if (!ram_load) ram_r_data = '0;
  end
  always @(posedge CLK) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 8'(i) ^ 8'h5A;
    end else if (ram_store && !ram_exception) begin
      ram_mem[ram_addr[7:0]] <= ram_w_data[7:0];
      if (ram_store_ops[1:0] != 2'd0) ram_mem[ram_addr[7:0] + 8'd1] <= ram_w_data[15:8];
      if (ram_store_ops[1:0] == 2'd2) begin
        ram_mem[ram_addr[7:0] + 8'd2] <= ram_w_data[23:16];
        ram_mem[ram_addr[7:0] + 8'd3] <= ram_w_data[31:24];
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [256];
  bit          active = 0, last_d = 0, t_d, t_ld, t_st, t_mis;
  int          cyc = 0, g_cyc = 0;
  logic [31:0] t_addr, t_wd, m_if_rd = '0, m_d_rd = '0;
  logic [2:0]  t_ops;

  function automatic bit misal(input bit isd, input logic [2:0] ops, input logic [31:0] a);
    if (!MIS_EN) return 1'b0;
    if (!isd) return a[1:0] != 2'd0;
    if (ops[1:0] == 2'd1) return a[0];
    if (ops[1:0] == 2'd2) return a[1:0] != 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] ops);
    int n = 1 << ops[1:0];
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[8'(a[7:0] + 8'(i))];
    if (!ops[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
        active = 0; last_d = 0; m_if_rd = '0; m_d_rd = '0;
      end else begin
        cyc++;
        if (active && cyc == g_cyc + 1) begin
          if (!t_d) m_if_rd = t_mis ? '0 : ref_load(t_addr, 3'd2);
          else if (t_st) begin
            if (!d_kill && !t_mis)
              for (int i = 0; i < (1 << t_ops[1:0]); i++) ref_mem[8'(t_addr[7:0] + 8'(i))] = t_wd[8*i +: 8];
            m_d_rd = '0;
          end else m_d_rd = (d_kill || t_mis) ? '0 : ref_load(t_addr, t_ops);
        end
        if (active && cyc >= g_cyc + 3) active = 0;
        if (!active && (if_req || d_req)) begin
          t_d = d_req && (!if_req || !last_d);
          t_addr = t_d ? d_addr : if_addr;
          t_wd = d_wdata; t_ld = d_load; t_st = d_store; t_ops = d_ops;
          t_mis = misal(t_d, d_ops, t_addr);
          last_d = t_d; active = 1; g_cyc = cyc;
        end
      end
    end
  end

  // per-cycle compare, away from the active edge
  initial forever begin
    int  k;
    bit  iss, rsp, e_ld, e_st;
    @(negedge CLK);
    k   = cyc - g_cyc;
    iss = active && k == 0;
    rsp = active && k == 1;
    e_ld = iss && !t_mis && (!t_d || t_ld);
    e_st = iss && !t_mis && t_d && t_st;
    chk("ram_load", ram_load, e_ld);
    chk("ram_store", ram_store, e_st);
    chk("ram_exception", ram_exception, (iss && t_d) ? d_kill : 1'b0);
    chk("ram_addr", ram_addr, iss ? t_addr : 32'd0);
    if (!iss || t_d) chk("ram_w_data", ram_w_data, iss ? t_wd : 32'd0);
    if (e_ld) chk("ram_load_ops", ram_load_ops, t_d ? t_ops : 3'd2);
    if (!iss) chk("ram_load_ops_idle", ram_load_ops, 3'd0);
    if (e_st) chk("ram_store_ops", ram_store_ops, t_ops);
    if (!iss) chk("ram_store_ops_idle", ram_store_ops, 3'd0);
    chk("if_ack", if_ack, rsp && !t_d);
    chk("d_ack", d_ack, rsp && t_d);
    chk("d_err", d_err, rsp && t_d && t_mis);
    chk("if_rdata", if_rdata, m_if_rd);
    chk("d_rdata", d_rdata, m_d_rd);
  end

  // ---------------- stimulus ----------------
  task automatic d_access(input logic ld, st, input logic [2:0] ops, input logic [31:0] a, wd,
                          input logic kill, output logic [31:0] rd, output logic err);
    bit found = 0;
    rd = 'x; err = 'x;
    @(posedge CLK); #1;
    d_req = 1; d_load = ld; d_store = st; d_ops = ops; d_addr = a; d_wdata = wd; d_kill = kill;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      if (d_ack) begin found = 1; rd = d_rdata; err = d_err; end
    end
    chk("d_ack_seen", found, 1'b1);
    @(posedge CLK); #1;
    d_req = 0; d_kill = 0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err, fa, da;
    int          n, stamp[4];
    bit          ord[4];
    RST_N = 1; init_mem = 1;
    if_req = 0; if_addr = '0; d_req = 0; d_addr = '0; d_wdata = '0;
    d_load = 0; d_store = 0; d_ops = '0; d_kill = 0;
    #1 RST_N = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_if_ack", if_ack, 1'b0);
    chk("rst_ram_load", ram_load, 1'b0);
    RST_N = 1; init_mem = 0;

    // tie from reset: data wins first, then strict alternation every 3 cycles
    @(posedge CLK); #1;
    if_req = 1; if_addr = 32'h0; d_req = 1; d_load = 1; d_store = 0; d_ops = 3'd4; d_addr = 32'h13;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge CLK);
      if (if_ack || d_ack) begin
        ord[n] = d_ack; stamp[n] = i;
        if (d_ack) chk("tie_lbu_rdata", d_rdata, 32'h0000_0049);
        else       chk("tie_fetch_rdata", if_rdata, 32'h5958_5B5A);
        n++;
      end
    end
    chk("tie_count", n, 4);
    if (n == 4) begin
      chk("tie_order", {ord[0], ord[1], ord[2], ord[3]}, 4'b1010);
      for (int i = 1; i < 4; i++) chk("tie_spacing", stamp[i] - stamp[i-1], 3);
    end
    @(posedge CLK); #1;
    if_req = 0; d_req = 0;

    d_access(0, 1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0, rd, err);
    chk("sw_rdata", rd, 32'h0);
    d_access(1, 0, 3'd2, 32'h10, 32'h0, 0, rd, err);
    chk("lw_after_sw", rd, 32'hDEAD_BEEF);
    d_access(0, 1, 3'd0, 32'h13, 32'h0000_0080, 0, rd, err);
    d_access(1, 0, 3'd0, 32'h13, 32'h0, 0, rd, err);
    chk("lb_sext", rd, 32'hFFFF_FF80);
    d_access(1, 0, 3'd4, 32'h13, 32'h0, 0, rd, err);
    chk("lbu_zext", rd, 32'h0000_0080);
    d_access(0, 1, 3'd2, 32'h20, 32'hCAFE_F00D, 1, rd, err);
    chk("killed_sw_rdata", rd, 32'h0);
    d_access(1, 0, 3'd2, 32'h20, 32'h0, 0, rd, err);
    chk("lw_after_kill", rd, 32'h7978_7B7A);

    // reset pulled during ISSUE of a store
    @(posedge CLK); #1;
    d_req = 1; d_load = 0; d_store = 1; d_ops = 3'd2; d_addr = 32'h30; d_wdata = 32'h1234_5678;
    @(posedge CLK); #1;
    chk("rst_mid_issue_store", ram_store, 1'b1);
    #2 RST_N = 0;
    #1;
    chk("rst_mid_store_drop", ram_store, 1'b0);
    chk("rst_mid_d_ack", d_ack, 1'b0);
    d_req = 0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1;
    repeat (4) begin
      @(negedge CLK);
      chk("rst_mid_no_ack", d_ack, 1'b0);
    end
    d_access(1, 0, 3'd2, 32'h30, 32'h0, 0, rd, err);
    chk("lw_after_rst_store", rd, 32'h6968_6B6A);

    d_access(1, 0, 3'd2, 32'h02, 32'h0, 0, rd, err);
    if (MIS_EN) begin
      chk("mis_lw_err", err, 1'b1);
      chk("mis_lw_rdata", rd, 32'h0);
    end else begin
      chk("unal_lw_err", err, 1'b0);
      chk("unal_lw_rdata", rd, 32'h5F5E_5958);
    end
    d_access(0, 1, 3'd1, 32'h04, 32'h0000_BEEF, 0, rd, err);
    chk("sh_aligned_err", err, 1'b0);

    // randomized two-port traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      fa = if_ack; da = d_ack;
      @(posedge CLK); #1;
      if ((if_req && fa && $urandom_range(0, 2) == 0) || (!if_req && $urandom_range(0, 1) == 0)) begin
        if_req = 1;
        if_addr = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 63) * 4);
      end else if (if_req && fa) if_req = 0;
      if ((d_req && da && $urandom_range(0, 2) == 0) || (!d_req && $urandom_range(0, 1) == 0)) begin
        d_req = 1;
        d_store = 1'($urandom_range(0, 1));
        d_load = ~d_store;
        if (d_store) d_ops = 3'($urandom_range(0, 2));
        else begin
          n = $urandom_range(0, 4);
          d_ops = (n < 3) ? 3'(n) : 3'(n + 1);
        end
        d_addr = 32'($urandom_range(0, 255));
        d_wdata = $urandom;
      end else if (d_req && da) d_req = 0;
      d_kill = ($urandom_range(0, 5) == 0);
    end
    @(posedge CLK); #1;
    if_req = 0; d_req = 0; d_kill = 0;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
